// File: rtl/snoop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snoop_pkg
//  Description : Shared bus opcodes, FSM state type and counter width for
//                the snoop memory block.
//  Revision    : 1.0 - initial release
// ============================================================================
package snoop_pkg;

    // Bus opcodes carried on bus_op
    localparam logic [1:0] OP_READ_MISS  = 2'd0;
    localparam logic [1:0] OP_WRITE_BACK = 2'd1;
    localparam logic [1:0] OP_WRITE_MISS = 2'd2;
    localparam logic [1:0] OP_INVALIDATE = 2'd3;

    // Latency counter width: LATENCY up to 15, so a load of up to 13 fits
    localparam int CNT_W = 4;

    // Request/response sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : snoop_pkg
`default_nettype wire

// File: rtl/snoop_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : snoop_mem_array
//  Description : 2**TAG_W x DATA_W word store. Synchronous write,
//                asynchronous read, synchronous clear of every word on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module snoop_mem_array
    import snoop_pkg::*;
#(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [TAG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [TAG_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**TAG_W];

    // Word storage: clear everything on reset, otherwise write when enabled
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2**TAG_W; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : snoop_mem_array
`default_nettype wire

// File: rtl/snoop_memory.sv
`default_nettype none
// ============================================================================
//  Module      : snoop_memory
//  Description : Snooping-bus backing memory. writeBack stores a word,
//                invalidate is a no-op, readMiss/writeMiss return the word
//                at the tag LATENCY cycles after acceptance.
//                Optional statistics counters: define SNOOP_MEM_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module snoop_memory
    import snoop_pkg::*;
#(
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 4,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_valid,
    output logic              bus_ready,
    input  logic [1:0]        bus_op,
    input  logic [TAG_W-1:0]  bus_tag,
    input  logic [DATA_W-1:0] bus_data,
    output logic              resp_valid,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [DATA_W-1:0] resp_data,
    output logic [15:0]       rd_count,
    output logic [15:0]       wb_count
);

    // Counter preload; WAIT lasts (load + 1) cycles, so LATENCY-2 gives LATENCY total
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] w_rdata;
    logic              w_accept;
    logic              w_is_read;
    logic              w_is_wb;
    logic              w_resp;

    // Ready only when idle; reset blocks acceptance in the same cycle
    assign bus_ready = (r_state == IDLE) && !reset;
    assign w_accept  = bus_valid && bus_ready;
    assign w_is_read = (bus_op == OP_READ_MISS) || (bus_op == OP_WRITE_MISS);
    assign w_is_wb   = (bus_op == OP_WRITE_BACK);

    snoop_mem_array #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (w_accept && w_is_wb),
        .waddr (bus_tag),
        .wdata (bus_data),
        .raddr (r_tag),
        .rdata (w_rdata)
    );

    // State and latency counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the tag of an accepted read for the response phase
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag <= '0;
        end else if (w_accept && w_is_read) begin
            r_tag <= bus_tag;
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_read) begin
                    if (LATENCY == 1) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = c_cnt_load;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Response is a one-cycle pulse in RESP; reset suppresses it immediately
    assign w_resp     = (r_state == RESP) && !reset;
    assign resp_valid = w_resp;
    assign resp_tag   = w_resp ? r_tag   : '0;
    assign resp_data  = w_resp ? w_rdata : '0;

`ifdef SNOOP_MEM_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wb_count;

    // Saturating counts of accepted reads and writeBacks
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_count <= '0;
            r_wb_count <= '0;
        end else begin
            if (w_accept && w_is_read && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_accept && w_is_wb && (r_wb_count != 16'hFFFF)) begin
                r_wb_count <= r_wb_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wb_count = r_wb_count;
`else
    assign rd_count = '0;
    assign wb_count = '0;
`endif

endmodule : snoop_memory
`default_nettype wire

// File: tb/tb_snoop_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snoop_memory
//  Description : Directed self-checking bench. Three instances (LATENCY 2,
//                1 and 15) share one request bus; the LATENCY=2 instance is
//                the primary one for data, handshake and statistics checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_memory;

    logic       clk;
    logic       reset;
    logic       bus_valid;
    logic [1:0] bus_op;
    logic [2:0] bus_tag;
    logic [3:0] bus_data;

    logic        rdy2, rdy1, rdy15;
    logic        rv2, rv1, rv15;
    logic [2:0]  rt2, rt1, rt15;
    logic [3:0]  rd2, rd1, rd15;
    logic [15:0] rc2, rc1, rc15;
    logic [15:0] wc2, wc1, wc15;

    int n_cmp;
    int n_err;

    // Results of the most recent read_req
    int         lat2, lat1, lat15;
    int         p2, p1, p15;
    logic [2:0] got_tag;
    logic [3:0] got_data;

    snoop_memory #(.TAG_W(3), .DATA_W(4), .LATENCY(2)) u_dut (
        .clock(clk), .reset(reset), .bus_valid(bus_valid), .bus_ready(rdy2),
        .bus_op(bus_op), .bus_tag(bus_tag), .bus_data(bus_data),
        .resp_valid(rv2), .resp_tag(rt2), .resp_data(rd2),
        .rd_count(rc2), .wb_count(wc2)
    );

    snoop_memory #(.TAG_W(3), .DATA_W(4), .LATENCY(1)) u_dut1 (
        .clock(clk), .reset(reset), .bus_valid(bus_valid), .bus_ready(rdy1),
        .bus_op(bus_op), .bus_tag(bus_tag), .bus_data(bus_data),
        .resp_valid(rv1), .resp_tag(rt1), .resp_data(rd1),
        .rd_count(rc1), .wb_count(wc1)
    );

    snoop_memory #(.TAG_W(3), .DATA_W(4), .LATENCY(15)) u_dut15 (
        .clock(clk), .reset(reset), .bus_valid(bus_valid), .bus_ready(rdy15),
        .bus_op(bus_op), .bus_tag(bus_tag), .bus_data(bus_data),
        .resp_valid(rv15), .resp_tag(rt15), .resp_data(rd15),
        .rd_count(rc15), .wb_count(wc15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle reset pulse; checks ready low during and high after
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus_valid = 1'b0;
        #1;
        n_cmp++;
        if (rdy2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_low: got %b need 0", rdy2);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rdy2 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_high: got %b need 1", rdy2);
        end
    endtask

    // Issue one read-type request and watch all instances for 20 cycles
    task automatic read_req(input logic [1:0] op, input logic [2:0] tag);
        @(negedge clk);
        bus_valid = 1'b1;
        bus_op    = op;
        bus_tag   = tag;
        bus_data  = 4'h0;
        #1;
        n_cmp++;
        if (rdy2 !== 1'b1) begin
            n_err++;
            $display("FAIL read_ready: got %b need 1", rdy2);
        end
        @(negedge clk);
        bus_valid = 1'b0;
        lat2 = 0; lat1 = 0; lat15 = 0;
        p2 = 0; p1 = 0; p15 = 0;
        got_tag = '0; got_data = '0;
        for (int n = 1; n <= 20; n++) begin
            if (rv2) begin
                if (lat2 == 0) begin
                    lat2 = n;
                    got_tag = rt2;
                    got_data = rd2;
                end
                p2++;
            end
            if (rv1) begin
                if (lat1 == 0) lat1 = n;
                p1++;
            end
            if (rv15) begin
                if (lat15 == 0) lat15 = n;
                p15++;
            end
            @(negedge clk);
        end
    endtask

    // Non-read request (writeBack/invalidate); no response may follow
    task automatic simple_req(input logic [1:0] op, input logic [2:0] tag,
                              input logic [3:0] data, input string name);
        int pulses;
        @(negedge clk);
        bus_valid = 1'b1;
        bus_op    = op;
        bus_tag   = tag;
        bus_data  = data;
        @(negedge clk);
        bus_valid = 1'b0;
        pulses = 0;
        for (int n = 0; n < 4; n++) begin
            if (rv2 || rv1 || rv15) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL %s_no_resp: got %0d pulses need 0", name, pulses);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({rv2, rt2, rd2} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_resp: got %b/%h/%h need 0/0/0", rv2, rt2, rd2);
        end
        n_cmp++;
        if ({rc2, wc2} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_counts: got %h/%h need 0/0", rc2, wc2);
        end
    endtask

    task automatic test_read_latency();
        read_req(2'd0, 3'd5);
        n_cmp++;
        if (lat2 != 2 || p2 != 1) begin
            n_err++;
            $display("FAIL lat2: got lat %0d pulses %0d need 2/1", lat2, p2);
        end
        n_cmp++;
        if (got_tag !== 3'd5 || got_data !== 4'h0) begin
            n_err++;
            $display("FAIL read5: got tag %0d data %h need 5/0", got_tag, got_data);
        end
        n_cmp++;
        if (lat1 != 1 || p1 != 1) begin
            n_err++;
            $display("FAIL lat1: got lat %0d pulses %0d need 1/1", lat1, p1);
        end
        n_cmp++;
        if (lat15 != 15 || p15 != 1) begin
            n_err++;
            $display("FAIL lat15: got lat %0d pulses %0d need 15/1", lat15, p15);
        end
    endtask

    task automatic test_writeback();
        simple_req(2'd1, 3'd3, 4'hA, "wb3");
        read_req(2'd2, 3'd3);
        n_cmp++;
        if (lat2 != 2 || got_tag !== 3'd3 || got_data !== 4'hA) begin
            n_err++;
            $display("FAIL read3: got lat %0d tag %0d data %h need 2/3/a", lat2, got_tag, got_data);
        end
    endtask

    task automatic test_invalidate();
        simple_req(2'd1, 3'd2, 4'h7, "wb2");
        simple_req(2'd3, 3'd2, 4'h0, "inv2");
        read_req(2'd0, 3'd2);
        n_cmp++;
        if (got_tag !== 3'd2 || got_data !== 4'h7) begin
            n_err++;
            $display("FAIL read2_after_inv: got tag %0d data %h need 2/7", got_tag, got_data);
        end
    endtask

    task automatic test_stats();
        logic [15:0] exp_rd;
        logic [15:0] exp_wb;
`ifdef SNOOP_MEM_STATS_EN
        exp_rd = 16'd3;
        exp_wb = 16'd2;
`else
        exp_rd = 16'd0;
        exp_wb = 16'd0;
`endif
        n_cmp++;
        if (rc2 !== exp_rd || wc2 !== exp_wb) begin
            n_err++;
            $display("FAIL stats: got rd %0d wb %0d need %0d/%0d", rc2, wc2, exp_rd, exp_wb);
        end
    endtask

    // Request held valid across a read: ready pattern 1,0,0 repeating
    task automatic test_back_to_back();
        logic [5:0] rdy_seen;
        logic [5:0] rv_seen;
        @(negedge clk);
        bus_valid = 1'b1;
        bus_op    = 2'd0;
        bus_tag   = 3'd3;
        for (int n = 0; n < 6; n++) begin
            #1;
            rdy_seen[n] = rdy2;
            rv_seen[n]  = rv2;
            @(negedge clk);
        end
        bus_valid = 1'b0;
        n_cmp++;
        if (rdy_seen !== 6'b001001) begin
            n_err++;
            $display("FAIL b2b_ready: got %b need 001001", rdy_seen);
        end
        n_cmp++;
        if (rv_seen !== 6'b100100) begin
            n_err++;
            $display("FAIL b2b_resp: got %b need 100100", rv_seen);
        end
        repeat (20) @(negedge clk);
    endtask

    // Reset while the LATENCY=2 and 15 instances sit in WAIT
    task automatic test_reset_abort();
        int pulses;
        simple_req(2'd1, 3'd4, 4'h9, "wb4");
        @(negedge clk);
        bus_valid = 1'b1;
        bus_op    = 2'd0;
        bus_tag   = 3'd4;
        @(negedge clk);
        bus_valid = 1'b0;
        reset     = 1'b1;
        #1;
        n_cmp++;
        if (rdy2 !== 1'b0 || rv2 !== 1'b0) begin
            n_err++;
            $display("FAIL abort_in_reset: got ready %b resp %b need 0/0", rdy2, rv2);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rdy2 !== 1'b1) begin
            n_err++;
            $display("FAIL abort_ready: got %b need 1", rdy2);
        end
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            if (rv2 || rv15) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL abort_no_resp: got %0d pulses need 0", pulses);
        end
        read_req(2'd0, 3'd4);
        n_cmp++;
        if (lat2 != 2 || got_tag !== 3'd4 || got_data !== 4'h0) begin
            n_err++;
            $display("FAIL abort_mem_clear: got lat %0d tag %0d data %h need 2/4/0", lat2, got_tag, got_data);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus_valid = 1'b0;
        bus_op    = 2'd0;
        bus_tag   = 3'd0;
        bus_data  = 4'h0;
        repeat (2) @(negedge clk);

        test_reset();
        test_read_latency();
        test_writeback();
        test_invalidate();
        test_stats();
        test_back_to_back();
        test_reset_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no finish need finish");
        $fatal(1, "timeout");
    end

endmodule : tb_snoop_memory
`default_nettype wire
